// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MIPS memory stage. Holds the E/M pipeline register and a
//                word-organised data memory; executes byte/half/word loads and
//                stores with alignment checking, and clears the memory after
//                every reset while reporting busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int DM_WORDS = 1024,
    parameter int ADDR_W   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_M_I,
    input  logic        flush_M_I,
    input  logic [31:0] ALURS_M_I,
    input  logic [31:0] WD_M_I,
    input  logic        RFWr_M_I,
    input  logic [4:0]  DstE_M_I,
    input  logic [31:0] Instr_M_I,
    input  logic [31:0] PC_M_I,
    input  logic        ForwardRtM_M_I,
    input  logic [31:0] TWF_M_I,
    output logic [31:0] TMF_M_O,
    output logic [31:0] RD_M_O,
    output logic [31:0] ALURS_M_O,
    output logic [31:0] PC_M_O,
    output logic [31:0] Instr_M_O,
    output logic [4:0]  DstE_M_O,
    output logic        RFWr_M_O,
    output logic        AdEL_M_O,
    output logic        AdES_M_O,
    output logic        busy_M_O
);

    // Clearing sequencer states
    localparam logic [0:0] c_st_clear = 1'b0;
    localparam logic [0:0] c_st_run   = 1'b1;

    // Memory opcodes (Instr[31:26])
    localparam logic [5:0] c_op_lb  = 6'h20;
    localparam logic [5:0] c_op_lh  = 6'h21;
    localparam logic [5:0] c_op_lw  = 6'h23;
    localparam logic [5:0] c_op_lbu = 6'h24;
    localparam logic [5:0] c_op_lhu = 6'h25;
    localparam logic [5:0] c_op_sb  = 6'h28;
    localparam logic [5:0] c_op_sh  = 6'h29;
    localparam logic [5:0] c_op_sw  = 6'h2b;

    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(DM_WORDS - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_idx;

    logic [31:0] r_alurs;
    logic [31:0] r_wd;
    logic        r_rfwr;
    logic [4:0]  r_dste;
    logic [31:0] r_instr;
    logic [31:0] r_pc;

    logic [31:0] r_mem [0:DM_WORDS-1];

    logic [5:0]        w_op;
    logic [31:0]       w_addr;
    logic [ADDR_W-1:0] w_idx;
    logic              w_is_lb, w_is_lh, w_is_lw, w_is_lbu, w_is_lhu;
    logic              w_is_sb, w_is_sh, w_is_sw;
    logic              w_ade_l, w_ade_s;
    logic [31:0]       w_rword;
    logic [7:0]        w_rbyte;
    logic [15:0]       w_rhalf;
    logic [31:0]       w_rd;
    logic [31:0]       w_sd;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_commit;
    logic              w_clearing;

    // Sequencer: walk every word once after reset, then run
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= c_st_clear;
            r_clr_idx <= '0;
        end else if (r_state == c_st_clear) begin
            r_clr_idx <= r_clr_idx + ADDR_W'(1);
            if (r_clr_idx == c_last_idx) begin
                r_state <= c_st_run;
            end
        end
    end

    // E/M pipeline register: bubble on reset/clear/flush, hold on stall
    always_ff @(posedge clk) begin
        if (!reset || (r_state == c_st_clear) || flush_M_I) begin
            r_alurs <= '0;
            r_wd    <= '0;
            r_rfwr  <= 1'b0;
            r_dste  <= '0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (!stall_M_I) begin
            r_alurs <= ALURS_M_I;
            r_wd    <= WD_M_I;
            r_rfwr  <= RFWr_M_I;
            r_dste  <= DstE_M_I;
            r_instr <= Instr_M_I;
            r_pc    <= PC_M_I;
        end
    end

    assign w_op     = r_instr[31:26];
    assign w_addr   = r_alurs;
    assign w_idx    = r_alurs[ADDR_W+1:2];
    assign w_is_lb  = (w_op == c_op_lb);
    assign w_is_lh  = (w_op == c_op_lh);
    assign w_is_lw  = (w_op == c_op_lw);
    assign w_is_lbu = (w_op == c_op_lbu);
    assign w_is_lhu = (w_op == c_op_lhu);
    assign w_is_sb  = (w_op == c_op_sb);
    assign w_is_sh  = (w_op == c_op_sh);
    assign w_is_sw  = (w_op == c_op_sw);

    assign w_ade_l = (w_is_lw & (w_addr[1:0] != 2'b00)) | ((w_is_lh | w_is_lhu) & w_addr[0]);
    assign w_ade_s = (w_is_sw & (w_addr[1:0] != 2'b00)) | (w_is_sh & w_addr[0]);

    assign w_rword = r_mem[w_idx];
    assign w_rbyte = w_rword[{w_addr[1:0], 3'b000} +: 8];
    assign w_rhalf = w_rword[{w_addr[1], 4'b0000} +: 16];

    // Load extraction and extension; misaligned or non-load reads return 0
    always_comb begin
        w_rd = '0;
        if (!w_ade_l) begin
            if (w_is_lw)  w_rd = w_rword;
            if (w_is_lh)  w_rd = {{16{w_rhalf[15]}}, w_rhalf};
            if (w_is_lhu) w_rd = {16'h0000, w_rhalf};
            if (w_is_lb)  w_rd = {{24{w_rbyte[7]}}, w_rbyte};
            if (w_is_lbu) w_rd = {24'h000000, w_rbyte};
        end
    end

    assign w_sd = ForwardRtM_M_I ? TWF_M_I : r_wd;

    // Store lane enables; narrow data is replicated so each lane sees it
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = w_sd;
        if (w_is_sw) begin
            w_be = 4'b1111;
        end else if (w_is_sh) begin
            w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{w_sd[15:0]}};
        end else if (w_is_sb) begin
            w_be    = 4'b0001 << w_addr[1:0];
            w_wdata = {4{w_sd[7:0]}};
        end
    end

    assign w_clearing = reset && (r_state == c_st_clear);
    assign w_commit   = reset && (r_state == c_st_run) && (w_is_sw || w_is_sh || w_is_sb)
                        && !w_ade_s && !stall_M_I && !flush_M_I;

    // Data memory write port: clear sweep has priority, else byte-enabled store
    always_ff @(posedge clk) begin
        if (w_clearing) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    assign TMF_M_O   = r_alurs;
    assign RD_M_O    = w_rd;
    assign ALURS_M_O = r_alurs;
    assign PC_M_O    = r_pc;
    assign Instr_M_O = r_instr;
    assign DstE_M_O  = r_dste;
    assign RFWr_M_O  = r_rfwr & ~w_ade_l;
    assign AdEL_M_O  = w_ade_l;
    assign AdES_M_O  = w_ade_s;
    assign busy_M_O  = (r_state == c_st_clear);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage. A byte-addressed memory
//                model predicts every output each cycle; directed literal
//                expectations pin the model on the key scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int DMW = 1024;

    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2b;
    localparam logic [5:0] NOP = 6'h00;
    localparam logic [25:0] ILO = 26'h0A51234;

    logic        clk;
    logic        reset;
    logic        stall_M_I, flush_M_I;
    logic [31:0] ALURS_M_I, WD_M_I, Instr_M_I, PC_M_I, TWF_M_I;
    logic        RFWr_M_I, ForwardRtM_M_I;
    logic [4:0]  DstE_M_I;
    logic [31:0] TMF_M_O, RD_M_O, ALURS_M_O, PC_M_O, Instr_M_O;
    logic [4:0]  DstE_M_O;
    logic        RFWr_M_O, AdEL_M_O, AdES_M_O, busy_M_O;

    mem_stage #(.DM_WORDS(DMW), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset),
        .stall_M_I(stall_M_I), .flush_M_I(flush_M_I),
        .ALURS_M_I(ALURS_M_I), .WD_M_I(WD_M_I), .RFWr_M_I(RFWr_M_I),
        .DstE_M_I(DstE_M_I), .Instr_M_I(Instr_M_I), .PC_M_I(PC_M_I),
        .ForwardRtM_M_I(ForwardRtM_M_I), .TWF_M_I(TWF_M_I),
        .TMF_M_O(TMF_M_O), .RD_M_O(RD_M_O), .ALURS_M_O(ALURS_M_O),
        .PC_M_O(PC_M_O), .Instr_M_O(Instr_M_O), .DstE_M_O(DstE_M_O),
        .RFWr_M_O(RFWr_M_O), .AdEL_M_O(AdEL_M_O), .AdES_M_O(AdES_M_O),
        .busy_M_O(busy_M_O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Directed expectations handed to the compare process
    string       q_name[$];
    logic [31:0] q_act[$];
    logic [31:0] q_exp[$];

    // ---------------- behavioural model ----------------
    logic [31:0] mdl_mem [DMW];
    int          remain = DMW;
    logic        mvalid = 1'b0;
    logic [31:0] m_alurs = '0, m_wd = '0, m_instr = '0, m_pc = '0;
    logic        m_rfwr = 1'b0;
    logic [4:0]  m_dst = '0;

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        logic [31:0] w;
        w = mdl_mem[(a / 4) % DMW];
        return w[int'(a % 4) * 8 +: 8];
    endfunction

    function automatic logic mis_load(input logic [5:0] op, input logic [31:0] a);
        return (op == LW && (a % 4) != 0) || ((op == LH || op == LHU) && (a % 2) != 0);
    endfunction

    function automatic logic mis_store(input logic [5:0] op, input logic [31:0] a);
        return (op == SW && (a % 4) != 0) || (op == SH && (a % 2) != 0);
    endfunction

    function automatic logic [31:0] mdl_load(input logic [5:0] op, input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = mbyte(a); b1 = mbyte(a + 1); b2 = mbyte(a + 2); b3 = mbyte(a + 3);
        if (mis_load(op, a)) return 32'h0;
        case (op)
            LW:      return {b3, b2, b1, b0};
            LH:      return {{16{b1[7]}}, b1, b0};
            LHU:     return {16'h0, b1, b0};
            LB:      return {{24{b0[7]}}, b0};
            LBU:     return {24'h0, b0};
            default: return 32'h0;
        endcase
    endfunction

    initial begin : model
        logic [5:0]  op;
        logic [31:0] sd, ba;
        int          nb;
        forever begin
            @(posedge clk);
            if (!reset) begin
                for (int i = 0; i < DMW; i++) mdl_mem[i] = '0;
                remain = DMW;
                {m_alurs, m_wd, m_instr, m_pc, m_rfwr, m_dst} = '0;
            end else if (remain > 0) begin
                remain = remain - 1;
                {m_alurs, m_wd, m_instr, m_pc, m_rfwr, m_dst} = '0;
            end else begin
                op = m_instr[31:26];
                sd = ForwardRtM_M_I ? TWF_M_I : m_wd;
                nb = (op == SW) ? 4 : (op == SH) ? 2 : (op == SB) ? 1 : 0;
                if (nb > 0 && !mis_store(op, m_alurs) && !stall_M_I && !flush_M_I) begin
                    for (int i = 0; i < nb; i++) begin
                        ba = m_alurs + i;
                        mdl_mem[(ba / 4) % DMW][int'(ba % 4) * 8 +: 8] = sd[8*i +: 8];
                    end
                end
                if (flush_M_I) begin
                    {m_alurs, m_wd, m_instr, m_pc, m_rfwr, m_dst} = '0;
                end else if (!stall_M_I) begin
                    m_alurs = ALURS_M_I; m_wd = WD_M_I; m_instr = Instr_M_I;
                    m_pc = PC_M_I; m_rfwr = RFWr_M_I; m_dst = DstE_M_I;
                end
            end
            mvalid = 1'b1;
        end
    end

    // ---------------- compare process (sole owner of counters) ----------------
    initial begin : compare
        logic [168:0] act_v, exp_v;
        logic         adel, ades;
        forever begin
            @(negedge clk);
            if (mvalid) begin
                adel  = mis_load(m_instr[31:26], m_alurs);
                ades  = mis_store(m_instr[31:26], m_alurs);
                exp_v = {remain != 0, adel, ades, m_rfwr & ~adel, m_dst, m_alurs,
                         mdl_load(m_instr[31:26], m_alurs), m_alurs, m_pc, m_instr};
                act_v = {busy_M_O, AdEL_M_O, AdES_M_O, RFWr_M_O, DstE_M_O, TMF_M_O,
                         RD_M_O, ALURS_M_O, PC_M_O, Instr_M_O};
                n_checks++;
                if (act_v !== exp_v) begin
                    n_errors++;
                    $display("FAIL model_cmp @%0t: got %h want %h", $time, act_v, exp_v);
                end
            end
            while (q_name.size() > 0) begin
                string       nm;
                logic [31:0] a, e;
                nm = q_name.pop_front(); a = q_act.pop_front(); e = q_exp.pop_front();
                n_checks++;
                if (a !== e) begin
                    n_errors++;
                    $display("FAIL %s: got %h want %h", nm, a, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] pc = 32'h0040_0000;

    task automatic push(input string nm, input logic [31:0] a, input logic [31:0] e);
        q_name.push_back(nm); q_act.push_back(a); q_exp.push_back(e);
    endtask

    task automatic cyc(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic fwd, input logic [31:0] twf, input logic stall, input logic flush);
        Instr_M_I      = {op, ILO};
        ALURS_M_I      = addr;
        WD_M_I         = wd;
        RFWr_M_I       = (op == LW || op == LH || op == LHU || op == LB || op == LBU);
        DstE_M_I       = pc[6:2];
        PC_M_I         = pc;
        ForwardRtM_M_I = fwd;
        TWF_M_I        = twf;
        stall_M_I      = stall;
        flush_M_I      = flush;
        pc = pc + 4;
        @(posedge clk); #1;
    endtask

    task automatic op1(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd);
        cyc(op, addr, wd, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic wait_clear(input string nm);
        int cnt;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (busy_M_O && cnt < 1100);
        push(nm, cnt, 32'd1024);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset = 1'b0;
        {stall_M_I, flush_M_I, RFWr_M_I, ForwardRtM_M_I} = '0;
        {ALURS_M_I, WD_M_I, Instr_M_I, PC_M_I, TWF_M_I} = '0;
        DstE_M_I = '0;
        repeat (3) @(posedge clk);
        #1;
        push("reset_busy", {31'b0, busy_M_O}, 32'd1);
        push("reset_instr", Instr_M_O, 32'h0);
        reset = 1'b1;
        wait_clear("clear_len");

        op1(LW, 32'h0, 0);     push("lw_0",     RD_M_O, 32'h0);
        op1(LW, 32'h10, 0);    push("lw_10",    RD_M_O, 32'h0);
        op1(LW, 32'hFFC, 0);   push("lw_ffc",   RD_M_O, 32'h0);

        op1(SW, 32'h40, 32'h12345678);
        op1(LW, 32'h40, 0);    push("lw_40",    RD_M_O, 32'h12345678);
        op1(LW, 32'h1040, 0);  push("lw_wrap",  RD_M_O, 32'h12345678);

        op1(SB, 32'h41, 32'h000000AB);
        op1(LBU, 32'h41, 0);   push("lbu_41",   RD_M_O, 32'h000000AB);
        op1(LB, 32'h41, 0);    push("lb_41",    RD_M_O, 32'hFFFFFFAB);
        op1(LW, 32'h40, 0);    push("lw_40_sb", RD_M_O, 32'h1234AB78);

        op1(SH, 32'h42, 32'h00008001);
        op1(LH, 32'h42, 0);    push("lh_42",    RD_M_O, 32'hFFFF8001);
        op1(LHU, 32'h42, 0);   push("lhu_42",   RD_M_O, 32'h00008001);
        op1(SH, 32'h43, 32'h00005555);
        push("ades_43", {31'b0, AdES_M_O}, 32'd1);
        op1(LW, 32'h40, 0);    push("lw_40_sh", RD_M_O, 32'h8001AB78);
        op1(LW, 32'h42, 0);
        push("adel_42", {31'b0, AdEL_M_O}, 32'd1);
        push("rfwr_42", {31'b0, RFWr_M_O}, 32'd0);
        push("rd_42",   RD_M_O, 32'h0);

        // stalled store picks up the forwarded data of the releasing edge
        op1(SW, 32'h60, 32'h11111111);
        for (int i = 1; i <= 3; i++) begin
            cyc(LW, 32'h60, 0, 1'b1, 32'hA0000000 + i, 1'b1, 1'b0);
            push("stall_hold", Instr_M_O, {SW, ILO});
        end
        cyc(LW, 32'h60, 0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
        push("lw_60_fwd", RD_M_O, 32'hCAFEF00D);

        // stalled store then flushed: never writes
        op1(SW, 32'h68, 32'h77777777);
        cyc(NOP, 0, 0, 1'b1, 32'h99999999, 1'b1, 1'b0);
        cyc(NOP, 0, 0, 1'b1, 32'h88888888, 1'b1, 1'b0);
        cyc(LW, 32'h68, 0, 1'b0, 32'h0, 1'b1, 1'b1);
        push("flush_instr", Instr_M_O, 32'h0);
        push("flush_alurs", ALURS_M_O, 32'h0);
        op1(LW, 32'h68, 0);    push("lw_68",    RD_M_O, 32'h0);

        op1(SW, 32'h84, 32'h5A5A5A5A);
        cyc(LW, 32'h84, 0, 1'b0, 32'h0, 1'b0, 1'b1);
        op1(LW, 32'h84, 0);    push("lw_84",    RD_M_O, 32'h0);

        // reset mid-run re-clears memory
        op1(SW, 32'h80, 32'hDEADBEEF);
        op1(LW, 32'h80, 0);    push("lw_80",    RD_M_O, 32'hDEADBEEF);
        op1(NOP, 0, 0);
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        push("rerst_busy",  {31'b0, busy_M_O}, 32'd1);
        push("rerst_alurs", ALURS_M_O, 32'h0);
        reset = 1'b1;
        wait_clear("reclear_len");
        op1(LW, 32'h80, 0);    push("lw_80_clr", RD_M_O, 32'h0);
        op1(LW, 32'h40, 0);    push("lw_40_clr", RD_M_O, 32'h0);
        op1(NOP, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
